// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the sequential multiply/divide unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multdiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    localparam int          ITERS   = 32;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

endpackage

// File: rtl/multdiv_cla32.sv
// multdiv_cla32: 32-bit carry-lookahead adder, 4-bit lookahead groups with group carry chained.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i addends; cin_i carry in; sum_o 32-bit sum; cout_o carry out of bit 31.
module multdiv_cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g    = a_i & b_i;
    assign p    = a_i ^ b_i;
    assign c[0] = cin_i;

    for (genvar grp = 0; grp < 8; grp++) begin : g_grp
        localparam int B = 4 * grp;
        assign c[B+1] = g[B]   | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign sum_o  = p ^ c[31:0];
    assign cout_o = c[32];

endmodule

// File: rtl/multdiv_seq.sv
// multdiv_seq: signed 32-bit multiply / divide, one shared CLA adder sequenced by an FSM.
// Latency: fixed 36 edges from the start edge to DONE (one-cycle data_resultRDY pulse).
// Backpressure: starts are accepted only in IDLE or DONE; starts while busy are dropped.
// Ports: clock/reset (async, active-high); ctrl_MULT/ctrl_DIV start pulses (MULT wins);
//        data_operandA/B operands sampled with start; data_result, data_exception held from
//        DONE until next DONE; data_resultRDY completion pulse; busy high while computing.
module multdiv_seq
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32,               // only 32 is legal: the adder is fixed-width
    parameter int ITERS = multdiv_pkg::ITERS // must equal WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    state_t      state_q,  state_d;
    op_t         op_q,     op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] a_q,      a_d;      // operand A, then |A|
    logic [31:0] b_q,      b_d;      // operand B, then |B|
    logic [31:0] hi_q,     hi_d;     // MULT: product high half; DIV: partial remainder
    logic [31:0] lo_q,     lo_d;     // MULT: product low half;  DIV: quotient
    logic [4:0]  cnt_q,    cnt_d;
    logic        fix_ph_q, fix_ph_d;
    logic [31:0] res_q,    res_d;    // sign-corrected lo, produced in the first FIX cycle
    logic [31:0] result_q, result_d;
    logic        exc_q,    exc_d;

    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    logic        start;
    logic        neg;
    logic [31:0] div_t;
    logic [31:0] b_mag;

    assign start = ctrl_MULT | ctrl_DIV;
    assign neg   = sign_a_q ^ sign_b_q;
    assign div_t = {hi_q[30:0], lo_q[31]};

    multdiv_cla32 u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (add_cin),
        .sum_o (add_sum),
        .cout_o(add_cout)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        fix_ph_d = fix_ph_q;
        res_d    = res_q;
        result_d = result_q;
        exc_d    = exc_q;
        add_a    = '0;
        add_b    = '0;
        add_cin  = 1'b0;
        b_mag    = b_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = ABS_A;
                    op_d     = ctrl_MULT ? OP_MULT : OP_DIV;
                    a_d      = data_operandA;
                    b_d      = data_operandB;
                    sign_a_d = data_operandA[31];
                    sign_b_d = data_operandB[31];
                end else begin
                    state_d = IDLE;
                end
            end
            ABS_A: begin
                // Negation as ~x + 0 + 1; INT_MIN maps to itself and is read as unsigned 2^31.
                add_a   = ~a_q;
                add_cin = 1'b1;
                if (sign_a_q) begin
                    a_d = add_sum;
                end
                state_d = ABS_B;
            end
            ABS_B: begin
                add_a   = ~b_q;
                add_cin = 1'b1;
                b_mag   = sign_b_q ? add_sum : b_q;
                b_d     = b_mag;
                hi_d    = '0;
                lo_d    = (op_q == OP_MULT) ? b_mag : a_q;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                if (op_q == OP_MULT) begin
                    add_a = hi_q;
                    add_b = lo_q[0] ? a_q : 32'd0;
                    {hi_d, lo_d} = {add_cout, add_sum, lo_q[31:1]};
                end else begin
                    // Remainder stays below 2^32, so carry-out is exactly "no borrow".
                    add_a   = div_t;
                    add_b   = ~b_q;
                    add_cin = 1'b1;
                    if (add_cout) begin
                        hi_d = add_sum;
                        lo_d = {lo_q[30:0], 1'b1};
                    end else begin
                        hi_d = div_t;
                        lo_d = {lo_q[30:0], 1'b0};
                    end
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(ITERS - 1)) begin
                    state_d  = FIX;
                    fix_ph_d = 1'b0;
                end
            end
            FIX: begin
                if (!fix_ph_q) begin
                    // First FIX cycle: apply the result sign using the adder.
                    add_a    = ~lo_q;
                    add_cin  = 1'b1;
                    res_d    = neg ? add_sum : lo_q;
                    fix_ph_d = 1'b1;
                end else begin
                    // Second FIX cycle: classify exceptions and register the outputs.
                    fix_ph_d = 1'b0;
                    state_d  = DONE;
                    if (op_q == OP_MULT) begin
                        result_d = res_q;
                        exc_d    = (hi_q != 32'd0)
                                 | (lo_q[31] & !(neg && lo_q == INT_MIN));
                    end else if (b_q == 32'd0) begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                    end else if (sign_a_q && a_q == INT_MIN && sign_b_q && b_q == 32'd1) begin
                        result_d = INT_MIN;
                        exc_d    = 1'b1;
                    end else begin
                        result_d = res_q;
                        exc_d    = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            fix_ph_q <= 1'b0;
            res_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            fix_ph_q <= fix_ph_d;
            res_q    <= res_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: scoreboard bench for multdiv_seq with a plain-arithmetic reference model.
// Latency: expects data_resultRDY exactly 36 edges after each accepted start.
// Backpressure: stimulus waits for busy low before issuing a start.
module tb_multdiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    localparam logic [31:0] IMIN = 32'h8000_0000;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          hold_chk = 0;
    logic [31:0] hold_res = '0;
    logic        hold_exc = 1'b0;

    multdiv_seq dut (
        .clock         (clock),
        .reset         (reset),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference: true signed arithmetic on 64-bit integers.
    function automatic void model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic exc);
        longint sa = longint'($signed(a));
        longint sb_ = longint'($signed(b));
        longint p;
        if (is_mult) begin
            p   = sa * sb_;
            res = p[31:0];
            exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else if (a == IMIN && b == 32'hFFFF_FFFF) begin
            res = IMIN;
            exc = 1'b1;
        end else begin
            p   = sa / sb_;
            res = p[31:0];
            exc = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Called at posedge+1; the start is sampled on the following edge.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        int   waited = 0;
        exp_t e;
        while (busy && waited < 100) begin
            @(posedge clock); #1;
            waited++;
        end
        check("issue_wait_busy", {31'd0, busy}, 32'd0);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        model(m, a, b, e.res, e.exc);
        e.due = cyc + 37;
        sb.push_back(e);
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return IMIN;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every completion against the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (data_resultRDY) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: rdy=1 at cycle %0d, expected no completion", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", data_result, e.res);
                    check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                    check("latency_cycle", cyc, e.due);
                    check("busy_at_rdy", {31'd0, busy}, 32'd0);
                    hold_res = e.res;
                    hold_exc = e.exc;
                    hold_chk = 1;
                end
            end else if (hold_chk) begin
                check("result_hold", data_result, hold_res);
                check("exception_hold", {31'd0, data_exception}, {31'd0, hold_exc});
                hold_chk = 0;
            end
        end
    end

    initial begin
        int w;
        #1 reset = 1'b1;
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Directed cases.
        issue(1, 0, 32'd7, 32'hFFFF_FFFA);
        issue(1, 0, 32'h0001_0000, 32'h0001_0000);
        issue(1, 0, IMIN, 32'd1);
        issue(0, 1, 32'hFFFF_FF9C, 32'd7);
        issue(0, 1, 32'd5, 32'd0);
        issue(0, 1, IMIN, 32'hFFFF_FFFF);

        // Reset in the middle of a multiply.
        issue(1, 0, 32'd3, 32'd4);
        repeat (9) @(posedge clock);
        #1;
        check("busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset_result", data_result, 32'd0);
        check("midreset_exception", {31'd0, data_exception}, 32'd0);
        check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        hold_chk = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        issue(1, 0, 32'd3, 32'd4);

        // Both starts together: multiply wins. A later divide pulse while busy is dropped.
        issue(1, 1, 32'd6, 32'd3);
        repeat (4) @(posedge clock);
        #1;
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd5;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;

        // Back-to-back: the second start lands in the DONE cycle of the first.
        issue(1, 0, 32'd2, 32'd3);
        issue(0, 1, 32'd9, 32'd2);

        // Randomized operations with boundary-biased operands and random gaps.
        for (int i = 0; i < 40; i++) begin
            bit m;
            bit d;
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
            m = 1'($urandom_range(0, 1));
            d = m ? 1'($urandom_range(0, 1)) : 1'b1;
            issue(m, d, pick(), pick());
        end

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clock); #1;
            w++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (5) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
